bomb_sprite_fetch: RTL and testbench

Pixel-pipeline stage directly upstream of the bomb palette lookup. It converts the VGA scan position and the bomb's on-screen position into a sprite-ROM address and reads the 8-bit colour index back from an external synchronous ROM. It registers that index, with a hit flag, for the palette stage.
It also owns the bomb's fuse-flicker animation frame counter, which advances on vertical-frame boundaries.

---
 rtl/bomb_sprite_fetch_if.sv | 34 +++
 rtl/bomb_sprite_fetch.sv | 134 +++++++++++++
 tb/tb_bomb_sprite_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bomb_sprite_fetch_if.sv
// Pixel/ROM bus between the scan generator, the bomb sprite fetch stage,
// the sprite ROM and the palette stage. The slave modport is the fetch
// stage; the master modport is whatever drives it (scan logic + ROM).
interface bomb_sprite_fetch_if #(
  parameter int ADDR_W = 11,
  parameter int FRAMES = 2
);
  localparam int AF_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic              frame_start;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        bomb_x;
  logic [9:0]        bomb_y;
  logic              bomb_active;
  logic              flash_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        pix_index;
  logic              pix_hit;
  logic [AF_W-1:0]   anim_frame;

  modport slave (
    input  frame_start, DrawX, DrawY, bomb_x, bomb_y, bomb_active, flash_req,
    input  rom_data,
    output rom_addr, pix_index, pix_hit, anim_frame
  );

  modport master (
    output frame_start, DrawX, DrawY, bomb_x, bomb_y, bomb_active, flash_req,
    output rom_data,
    input  rom_addr, pix_index, pix_hit, anim_frame
  );
endinterface

// File: rtl/bomb_sprite_fetch.sv
// Bomb sprite fetch: maps scan position to a sprite-ROM address, reads the
// colour index back from a synchronous ROM and registers index + hit flag
// for the palette stage (3-cycle latency, one pixel per clock). Also owns
// the fuse-flicker animation frame counter.
// Optional feature macro: BOMB_FLASH_EN (red flash on alternate frames).
module bomb_sprite_fetch #(
  parameter int         SPRITE_W        = 32,
  parameter int         SPRITE_H        = 32,
  parameter int         FRAMES          = 2,
  parameter int         FRAME_HOLD      = 8,
  parameter logic [7:0] TRANSPARENT_IDX = 8'd255,
  parameter logic [7:0] FLASH_IDX       = 8'd5,
  parameter int         ADDR_W          = 11
) (
  input logic                Clk,
  input logic                Reset,
  bomb_sprite_fetch_if.slave bus
);
  localparam int AF_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HC_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
  // vld_pipe[0] travels with rom_addr, vld_pipe[STAGES] with rom_data
  localparam int STAGES   = 1;

  logic [9:0]        pos_x, pos_y;
  logic              act;
  logic [HC_W-1:0]   hold_cnt;
  logic [AF_W-1:0]   anim_frame;
  logic [STAGES:0]   vld_pipe;
  logic [10:0]       dx, dy, x_end, y_end;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] rom_addr;
  logic              hit_next;
  logic [7:0]        pix_index;
  logic              pix_hit;
  logic              flash_on;

  // Latch bomb position/visibility only at frame boundary so a frame never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x <= '0;
      pos_y <= '0;
      act   <= 1'b0;
    end else if (bus.frame_start) begin
      pos_x <= bus.bomb_x;
      pos_y <= bus.bomb_y;
      act   <= bus.bomb_active;
    end
  end

  // Animation counter; the pulse that latches visibility also decides whether
  // it counts, so a hidden bomb restarts its fuse from frame 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt   <= '0;
      anim_frame <= '0;
    end else if (bus.frame_start) begin
      if (!bus.bomb_active) begin
        hold_cnt   <= '0;
        anim_frame <= '0;
      end else if (hold_cnt == HC_W'(FRAME_HOLD - 1)) begin
        hold_cnt   <= '0;
        anim_frame <= (anim_frame == AF_W'(FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Box test at 11 bits so sprites hanging off the right/bottom edge clip, not wrap.
  always_comb begin
    x_end     = {1'b0, pos_x} + 11'(SPRITE_W);
    y_end     = {1'b0, pos_y} + 11'(SPRITE_H);
    dx        = {1'b0, bus.DrawX} - {1'b0, pos_x};
    dy        = {1'b0, bus.DrawY} - {1'b0, pos_y};
    in_box    = act
              & ({1'b0, bus.DrawX} >= {1'b0, pos_x}) & ({1'b0, bus.DrawX} < x_end)
              & ({1'b0, bus.DrawY} >= {1'b0, pos_y}) & ({1'b0, bus.DrawY} < y_end);
    addr_next = ADDR_W'(anim_frame) * ADDR_W'(FRAME_SZ)
              + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
              + ADDR_W'(dx);
  end

  // Stage 1: register ROM address and start the in-box valid shift register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      vld_pipe <= '0;
    end else begin
      rom_addr <= in_box ? addr_next : '0;
      vld_pipe <= {vld_pipe[STAGES-1:0], in_box};
    end
  end

  // ROM data is aligned with the last valid bit; transparent texels are no hit.
  always_comb begin
    hit_next = vld_pipe[STAGES] & (bus.rom_data != TRANSPARENT_IDX);
  end

  // Stage 3: register index and hit; non-hit pixels carry index 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_index <= '0;
      pix_hit   <= 1'b0;
    end else begin
      pix_hit   <= hit_next;
      pix_index <= hit_next ? (flash_on ? FLASH_IDX : bus.rom_data) : 8'd0;
    end
  end

`ifdef BOMB_FLASH_EN
  logic flash_tgl;

  // Flash phase flips once per frame while requested, clears as soon as it is dropped.
  always_ff @(posedge Clk) begin
    if (Reset)                flash_tgl <= 1'b0;
    else if (!bus.flash_req)  flash_tgl <= 1'b0;
    else if (bus.frame_start) flash_tgl <= ~flash_tgl;
  end

  assign flash_on = flash_tgl;
`else
  logic unused_flash_req;

  assign unused_flash_req = bus.flash_req;
  assign flash_on         = 1'b0;
`endif

  assign bus.rom_addr   = rom_addr;
  assign bus.pix_index  = pix_index;
  assign bus.pix_hit    = pix_hit;
  assign bus.anim_frame = anim_frame;
endmodule

// File: tb/tb_bomb_sprite_fetch.sv
// Scoreboard bench for bomb_sprite_fetch: stimulus pushes expected outputs
// computed from a plain arithmetic model of the sprite rules; a monitor
// pops and compares on every clock. Flash checks apply when BOMB_FLASH_EN
// is defined for both bench and design.
module tb_bomb_sprite_fetch;
  localparam int ADDR_W     = 11;
  localparam int FRAMES     = 2;
  localparam int FRAME_HOLD = 8;
  localparam int SW         = 32;
  localparam int SH         = 32;
  localparam int FLASH_IDX  = 5;

  typedef struct { int tag; int addr; int frame; } a_exp_t;
  typedef struct { int tag; bit hit; int idx; }    p_exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] rom_mem [0:2047];
  a_exp_t     aq[$];
  p_exp_t     pq[$];
  bit         tgl_hist [int];

  // model state
  int m_px = 0, m_py = 0, m_pulses = 0;
  bit m_act = 0, m_tgl = 0;

  bomb_sprite_fetch_if #(.ADDR_W(ADDR_W), .FRAMES(FRAMES)) bus ();

  bomb_sprite_fetch #(
    .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FRAMES), .FRAME_HOLD(FRAME_HOLD),
    .TRANSPARENT_IDX(8'd255), .FLASH_IDX(8'(FLASH_IDX)), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic chk(input string name, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%0d required=%0d", name, tag, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Drive one clock of inputs and record what the design must produce for it.
  task automatic step(input bit rst, input bit fs, input int x, input int y,
                      input int bx, input int by, input bit ba, input bit fl);
    int tag, addr, fr;
    bit inb, hit;
    logic [7:0] d;
    p_exp_t p;
    Reset           = rst;
    bus.frame_start = fs;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.bomb_x      = 10'(bx);
    bus.bomb_y      = 10'(by);
    bus.bomb_active = ba;
    bus.flash_req   = fl;
    tag = cyc + 1;
    if (rst) begin
      // anything still in flight is flushed
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].tag >= tag - 2) begin
          p = pq[i]; p.hit = 0; p.idx = 0; pq[i] = p;
        end
      m_px = 0; m_py = 0; m_act = 0; m_pulses = 0; m_tgl = 0;
      inb = 0; addr = 0;
    end else begin
      fr   = (m_pulses / FRAME_HOLD) % FRAMES;
      inb  = m_act && x >= m_px && x < m_px + SW && y >= m_py && y < m_py + SH;
      addr = inb ? fr * SW * SH + (y - m_py) * SW + (x - m_px) : 0;
      if (fs) begin
        m_px = bx; m_py = by; m_act = ba;
        m_pulses = ba ? m_pulses + 1 : 0;
      end
      m_tgl = fl ? (fs ? !m_tgl : m_tgl) : 1'b0;
    end
    tgl_hist[tag] = m_tgl;
    d   = rom_mem[addr];
    hit = inb && (d != 8'd255);
    aq.push_back('{tag, addr, (m_pulses / FRAME_HOLD) % FRAMES});
    pq.push_back('{tag, hit, hit ? int'(d) : 0});
    @(posedge Clk);
    #1;
  endtask

  // Monitor: rom_addr/anim_frame for tag=cyc, pixel outputs for tag=cyc-2.
  initial begin
    a_exp_t a;
    p_exp_t p;
    int     ei;
    forever begin
      @(negedge Clk);
      while (aq.size() > 0 && aq[0].tag <= cyc) begin
        a = aq.pop_front();
        if (a.tag == cyc) begin
          chk("rom_addr", a.tag, int'(bus.rom_addr), a.addr);
          chk("anim_frame", a.tag, int'(bus.anim_frame), a.frame);
        end else
          chk("addr_slot_missed", a.tag, 0, 1);
      end
      while (pq.size() > 0 && pq[0].tag <= cyc - 2) begin
        p = pq.pop_front();
        if (p.tag == cyc - 2) begin
          ei = p.idx;
`ifdef BOMB_FLASH_EN
          if (p.hit && tgl_hist.exists(p.tag + 1) && tgl_hist[p.tag + 1]) ei = FLASH_IDX;
`endif
          chk("pix_hit", p.tag, int'(bus.pix_hit), int'(p.hit));
          chk("pix_index", p.tag, int'(bus.pix_index), ei);
        end else
          chk("pix_slot_missed", p.tag, 0, 1);
      end
    end
  end

  initial begin
    int bx, by, x, y;
    bit ba, fs, rst, fl;
    for (int i = 0; i < 2048; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 254));
    rom_mem[0] = 8'd3;
    rom_mem[1] = 8'd255;
    rom_mem[2] = 8'd254;

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

    // origin, far corner, right edge, transparency
    step(0, 1, 0, 0, 100, 50, 1, 0);
    step(0, 0, 100, 50, 100, 50, 1, 0);
    step(0, 0, 131, 81, 100, 50, 1, 0);
    step(0, 0, 132, 81, 100, 50, 1, 0);
    step(0, 0, 101, 50, 100, 50, 1, 0);
    step(0, 0, 102, 50, 100, 50, 1, 0);
    // mid-frame position/active change must be ignored
    step(0, 0, 5, 5, 300, 300, 0, 0);
    step(0, 0, 100, 50, 300, 300, 0, 0);

    // 16 pulses total: frame 1 after the 8th, back to 0 after the 16th
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 0, 100, 50, 1, 1);
      step(0, 0, 100, 50, 100, 50, 1, 1);
      step(0, 0, 102, 50, 100, 50, 1, 1);
    end

    // right-edge clipping
    step(0, 1, 0, 0, 620, 200, 1, 0);
    step(0, 0, 639, 200, 620, 200, 1, 0);
    step(0, 0, 639, 231, 620, 200, 1, 0);
    step(0, 0, 619, 200, 620, 200, 1, 0);

    // inactive bomb: no hits, animation pinned at 0
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 100, 50, 0, 0);
      step(0, 0, 100, 50, 100, 50, 0, 0);
    end

    // reset while hits are in flight
    step(0, 1, 0, 0, 100, 50, 1, 0);
    step(0, 0, 100, 50, 100, 50, 1, 0);
    step(0, 0, 102, 50, 100, 50, 1, 0);
    step(1, 1, 100, 50, 100, 50, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 100, 50, 100, 50, 1, 0);

    // randomized traffic around the sprite
    bx = 100; by = 50; ba = 1; fl = 1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      fs  = ($urandom_range(0, 15) == 0);
      if (fs) begin
        bx = $urandom_range(0, 639);
        by = $urandom_range(0, 479);
        ba = ($urandom_range(0, 15) != 0);
      end else if ($urandom_range(0, 7) == 0) begin
        bx = $urandom_range(0, 639);
        by = $urandom_range(0, 479);
      end
      if ($urandom_range(0, 63) == 0) fl = !fl;
      x = clamp(m_px + int'($urandom_range(0, 44)) - 6, 0, 639);
      y = clamp(m_py + int'($urandom_range(0, 44)) - 6, 0, 479);
      step(rst, fs, x, y, bx, by, ba, fl);
    end

    for (int i = 0; i < 3; i++) step(0, 0, m_px, m_py, bx, by, ba, 0);
    repeat (4) @(negedge Clk);
    chk("addr_queue_drained", cyc, aq.size(), 0);
    chk("pix_queue_drained", cyc, pq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
